// File: rtl/color_classifier_mc.sv
// Multi-channel colour-sensor classifier: steps the shared S2/S3 filter select,
// counts synchronised wave edges per filter, then classifies and debounces each channel.
module color_classifier_mc #(
    parameter int NCH     = 2,
    parameter int PERIOD  = 2000,
    parameter int SETTLE  = 100,
    parameter int CW      = 10,
    parameter int MIN_CNT = 16,
    parameter int CONFIRM = 2,
    localparam int RDW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clkus,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NCH-1:0]    wave,
    output logic [1:0]        sel,
    output logic [2*NCH-1:0]  color,
    output logic              color_valid,
    input  logic [RDW-1:0]    rd_ch,
    output logic [CW-1:0]     rd_r,
    output logic [CW-1:0]     rd_g,
    output logic [CW-1:0]     rd_b
);

    localparam int PW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int NRD = 1 << RDW;
    localparam logic [PW-1:0] PH_LAST   = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PH_SETTLE = PW'(SETTLE);
    localparam logic [31:0]   MIN_U     = 32'(MIN_CNT);
    localparam logic [3:0]    CONF_MAX  = 4'(CONFIRM);
    localparam logic [1:0]    SEL_R     = 2'b00;
    localparam logic [1:0]    SEL_G     = 2'b11;
    localparam logic [1:0]    SEL_B     = 2'b01;

    typedef enum logic [1:0] {PH_R = 2'd0, PH_G = 2'd1, PH_B = 2'd2, CALC = 2'd3} state_t;

    // Dominance test: X minus a quarter of itself must beat both other counts.
    function automatic logic [1:0] classify(input logic [CW-1:0] cr,
                                            input logic [CW-1:0] cg,
                                            input logic [CW-1:0] cb);
        logic [CW-1:0] dr;
        logic [CW-1:0] dg;
        logic [CW-1:0] db;
        dr = cr - (cr >> 2);
        dg = cg - (cg >> 2);
        db = cb - (cb >> 2);
        if (32'(cr) >= MIN_U && dr > cg && dr > cb)
            classify = 2'd1;
        else if (32'(cg) >= MIN_U && dg > cr && dg > cb)
            classify = 2'd2;
        else if (32'(cb) >= MIN_U && db > cr && db > cg)
            classify = 2'd3;
        else
            classify = 2'd0;
    endfunction

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_phase;
    logic [PW-1:0]   w_phase_next;
    logic [1:0]      r_sel;
    logic [1:0]      w_sel_next;
    logic            w_calc;
    logic            w_clear;
    logic            w_in_window;
    logic            r_valid;

    logic [NCH-1:0]  r_sync1;
    logic [NCH-1:0]  r_sync2;
    logic [NCH-1:0]  r_sync_d;
    logic [NCH-1:0]  w_edge;

    logic [CW-1:0]   w_lat_r [NCH];
    logic [CW-1:0]   w_lat_g [NCH];
    logic [CW-1:0]   w_lat_b [NCH];
    logic [CW-1:0]   w_ext_r [NRD];
    logic [CW-1:0]   w_ext_g [NRD];
    logic [CW-1:0]   w_ext_b [NRD];
    logic [CW-1:0]   r_rd_r;
    logic [CW-1:0]   r_rd_g;
    logic [CW-1:0]   r_rd_b;

    always_ff @(posedge clkus or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PH_R;
            r_phase <= '0;
            r_sel   <= SEL_R;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_sel   <= w_sel_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_sel_next   = r_sel;
        w_calc       = 1'b0;
        w_clear      = 1'b0;
        if (!en) begin
            w_state_next = PH_R;
            w_phase_next = '0;
            w_sel_next   = SEL_R;
            w_clear      = 1'b1;
        end else begin
            unique case (r_state)
                PH_R: begin
                    if (r_phase == PH_LAST) begin
                        w_state_next = PH_G;
                        w_phase_next = '0;
                        w_sel_next   = SEL_G;
                    end else begin
                        w_phase_next = r_phase + 1'b1;
                    end
                end
                PH_G: begin
                    if (r_phase == PH_LAST) begin
                        w_state_next = PH_B;
                        w_phase_next = '0;
                        w_sel_next   = SEL_B;
                    end else begin
                        w_phase_next = r_phase + 1'b1;
                    end
                end
                PH_B: begin
                    if (r_phase == PH_LAST) begin
                        w_state_next = CALC;
                        w_phase_next = '0;
                    end else begin
                        w_phase_next = r_phase + 1'b1;
                    end
                end
                CALC: begin
                    w_calc       = 1'b1;
                    w_clear      = 1'b1;
                    w_state_next = PH_R;
                    w_sel_next   = SEL_R;
                end
                default: w_state_next = PH_R;
            endcase
        end
    end

    assign w_in_window = (r_phase >= PH_SETTLE);

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clkus or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync1  <= wave;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_sync_d;

    genvar gi;
    for (gi = 0; gi < NCH; gi++) begin : g_ch
        logic [CW-1:0] r_cnt_r;
        logic [CW-1:0] r_cnt_g;
        logic [CW-1:0] r_cnt_b;
        logic [CW-1:0] r_lat_r;
        logic [CW-1:0] r_lat_g;
        logic [CW-1:0] r_lat_b;
        logic [1:0]    r_cand;
        logic [1:0]    r_color;
        logic [3:0]    r_conf;
        logic [1:0]    w_raw;
        logic [1:0]    w_cand_next;
        logic [3:0]    w_conf_next;
        logic          w_hit;

        assign w_hit = w_edge[gi] & w_in_window;

        always_ff @(posedge clkus or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt_r <= '0;
                r_cnt_g <= '0;
                r_cnt_b <= '0;
            end else if (w_clear) begin
                r_cnt_r <= '0;
                r_cnt_g <= '0;
                r_cnt_b <= '0;
            end else if (w_hit) begin
                unique case (r_state)
                    PH_R: if (r_cnt_r != '1) r_cnt_r <= r_cnt_r + 1'b1;
                    PH_G: if (r_cnt_g != '1) r_cnt_g <= r_cnt_g + 1'b1;
                    PH_B: if (r_cnt_b != '1) r_cnt_b <= r_cnt_b + 1'b1;
                    default: ;
                endcase
            end
        end

        assign w_raw = classify(r_cnt_r, r_cnt_g, r_cnt_b);

        always_comb begin
            w_cand_next = w_raw;
            w_conf_next = 4'd1;
            if (w_raw == r_cand) begin
                w_cand_next = r_cand;
                w_conf_next = (r_conf >= CONF_MAX) ? CONF_MAX : r_conf + 4'd1;
            end
        end

        // Reported colour only moves once the candidate has been seen CONFIRM times.
        always_ff @(posedge clkus or negedge rst_n) begin
            if (!rst_n) begin
                r_lat_r <= '0;
                r_lat_g <= '0;
                r_lat_b <= '0;
                r_cand  <= 2'd0;
                r_conf  <= 4'd0;
                r_color <= 2'd0;
            end else if (w_calc) begin
                r_lat_r <= r_cnt_r;
                r_lat_g <= r_cnt_g;
                r_lat_b <= r_cnt_b;
                r_cand  <= w_cand_next;
                r_conf  <= w_conf_next;
                if (w_conf_next == CONF_MAX)
                    r_color <= w_cand_next;
            end
        end

        assign color[2*gi +: 2] = r_color;
        assign w_lat_r[gi] = r_lat_r;
        assign w_lat_g[gi] = r_lat_g;
        assign w_lat_b[gi] = r_lat_b;
    end

    // Pad the readback table to the full rd_ch range; unused slots read zero.
    for (gi = 0; gi < NRD; gi++) begin : g_rd
        if (gi < NCH) begin : g_used
            assign w_ext_r[gi] = w_lat_r[gi];
            assign w_ext_g[gi] = w_lat_g[gi];
            assign w_ext_b[gi] = w_lat_b[gi];
        end else begin : g_zero
            assign w_ext_r[gi] = '0;
            assign w_ext_g[gi] = '0;
            assign w_ext_b[gi] = '0;
        end
    end

    always_ff @(posedge clkus or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_r  <= '0;
            r_rd_g  <= '0;
            r_rd_b  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_rd_r  <= w_ext_r[rd_ch];
            r_rd_g  <= w_ext_g[rd_ch];
            r_rd_b  <= w_ext_b[rd_ch];
            r_valid <= w_calc;
        end
    end

    assign sel         = r_sel;
    assign color_valid = r_valid;
    assign rd_r        = r_rd_r;
    assign rd_g        = r_rd_g;
    assign rd_b        = r_rd_b;

endmodule

// File: tb/tb_color_classifier_mc.sv
// Scoreboard bench: stimulus pushes expected per-frame colour/count records,
// a monitor pops and compares them on each color_valid pulse.
module tb_color_classifier_mc;

    logic        clkus = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [1:0]  wave  = 2'b00;
    logic [1:0]  sel;
    logic [3:0]  color;
    logic        color_valid;
    logic [0:0]  rd_ch = 1'b0;
    logic [9:0]  rd_r, rd_g, rd_b;

    logic [1:0]  wave_s  = 2'b00;
    logic [1:0]  sel_s;
    logic [3:0]  color_s;
    logic        cv_s;
    logic [0:0]  rd_ch_s = 1'b0;
    logic [3:0]  rd_r_s, rd_g_s, rd_b_s;

    color_classifier_mc dut (
        .clkus(clkus), .rst_n(rst_n), .en(en), .wave(wave), .sel(sel),
        .color(color), .color_valid(color_valid), .rd_ch(rd_ch),
        .rd_r(rd_r), .rd_g(rd_g), .rd_b(rd_b)
    );

    color_classifier_mc #(.CW(4)) dut_sat (
        .clkus(clkus), .rst_n(rst_n), .en(en), .wave(wave_s), .sel(sel_s),
        .color(color_s), .color_valid(cv_s), .rd_ch(rd_ch_s),
        .rd_r(rd_r_s), .rd_g(rd_g_s), .rd_b(rd_b_s)
    );

    always #5 clkus = ~clkus;

    int ncyc = 0;
    always @(posedge clkus) ncyc <= ncyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] color;
        int t_exp;
        int rlo; int rhi;
        int glo; int ghi;
        int blo; int bhi;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%0d want=%0d", name, ncyc, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s t=%0d got=%0d want=%0d..%0d", name, ncyc, act, lo, hi);
        end
    endtask

    task automatic wait_until(input int t);
        while (ncyc < t) @(negedge clkus);
    endtask

    task automatic push_exp(input logic [3:0] c, input int t,
                            input int rlo, input int rhi, input int glo,
                            input int ghi, input int blo, input int bhi);
        exp_t e;
        e.color = c; e.t_exp = t;
        e.rlo = rlo; e.rhi = rhi; e.glo = glo; e.ghi = ghi; e.blo = blo; e.bhi = bhi;
        sb_q.push_back(e);
    endtask

    // Wave generator: half-period per channel per filter (0 = idle line),
    // or a burst of toggles confined to the first 85 cycles of each phase.
    int hp [2][3];
    bit settle_m = 1'b0;
    int wc [2];
    int pos = 0;
    logic [1:0] prev_sel = 2'b00;

    task automatic set_ch(input int k, input int r, input int g, input int b);
        hp[k][0] = r; hp[k][1] = g; hp[k][2] = b;
    endtask

    always @(negedge clkus) begin
        int idx;
        if (sel != prev_sel) pos = 0;
        else pos++;
        prev_sel = sel;
        idx = (sel == 2'b00) ? 0 : (sel == 2'b11) ? 1 : 2;
        for (int k = 0; k < 2; k++) begin
            if (settle_m) begin
                if (pos < 85) wave[k] = ~wave[k];
            end else if (hp[k][idx] == 0) begin
                wave[k] = 1'b0;
                wc[k] = 0;
            end else begin
                wc[k]++;
                if (wc[k] >= hp[k][idx]) begin
                    wave[k] = ~wave[k];
                    wc[k] = 0;
                end
            end
        end
        wave_s = ~wave_s;
    end

    // Monitor: pops one record per pulse; counts are compared one cycle later.
    exp_t cur;
    bit rd_pend = 1'b0;
    always @(negedge clkus) begin
        if (rd_pend) begin
            rd_pend = 1'b0;
            chk_rng("rd_r", int'(rd_r), cur.rlo, cur.rhi);
            chk_rng("rd_g", int'(rd_g), cur.glo, cur.ghi);
            chk_rng("rd_b", int'(rd_b), cur.blo, cur.bhi);
        end
        if (color_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse t=%0d got=1 want=0 color=%b", ncyc, color);
            end else begin
                cur = sb_q.pop_front();
                chk("color", int'(color), int'(cur.color));
                chk("pulse_time", ncyc, cur.t_exp);
                $display("frame t=%0d color=%b sel=%b rd_ch=%0d", ncyc, color, sel, rd_ch);
                rd_pend = 1'b1;
            end
        end
    end

    // Saturation instance: an edge every other cycle overruns a 4-bit counter.
    bit sat_done = 1'b0;
    initial begin
        int budget;
        budget = 0;
        @(posedge rst_n);
        while (!cv_s && budget < 20000) begin
            @(negedge clkus);
            budget++;
        end
        if (!cv_s) begin
            chk("sat_pulse_timeout", 0, 1);
        end else begin
            chk("sat_color", int'(color_s), 0);
            @(negedge clkus);
            chk("sat_rd_r", int'(rd_r_s), 15);
            chk("sat_rd_g", int'(rd_g_s), 15);
            chk("sat_rd_b", int'(rd_b_s), 15);
        end
        sat_done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0d got=timeout want=finish", ncyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, td, te, budget;
        for (int k = 0; k < 2; k++) begin
            set_ch(k, 0, 0, 0);
            wc[k] = 0;
        end

        repeat (3) @(negedge clkus);
        chk("rst_sel", int'(sel), 0);
        chk("rst_color", int'(color), 0);
        chk("rst_valid", int'(color_valid), 0);
        chk("rst_rd_r", int'(rd_r), 0);
        chk("rst_rd_g", int'(rd_g), 0);
        chk("rst_rd_b", int'(rd_b), 0);

        rst_n = 1'b1;
        repeat (3) @(negedge clkus);
        chk("idle_sel", int'(sel), 0);

        // Frame 1: no waves; check filter sequencing along the way.
        t0 = ncyc;
        en = 1'b1;
        push_exp(4'b0000, t0 + 6001, 0, 0, 0, 0, 0, 0);
        wait_until(t0 + 1000);  chk("sel_R", int'(sel), 0);
        wait_until(t0 + 3000);  chk("sel_G", int'(sel), 3);
        wait_until(t0 + 5000);  chk("sel_B", int'(sel), 1);
        wait_until(t0 + 6000);  chk("sel_calc", int'(sel), 1);

        // Frame 2: still idle, read channel 1.
        wait_until(t0 + 6001 + 2);
        rd_ch = 1'b1;
        push_exp(4'b0000, t0 + 2 * 6001, 0, 0, 0, 0, 0, 0);

        // Frames 3-4: channel 0 red, channel 1 blue; both confirm after two frames.
        wait_until(t0 + 2 * 6001 + 2);
        set_ch(0, 25, 100, 50);
        set_ch(1, 50, 50, 20);
        rd_ch = 1'b0;
        push_exp(4'b0000, t0 + 3 * 6001, 37, 39, 8, 10, 18, 20);
        wait_until(t0 + 3 * 6001 + 2);
        rd_ch = 1'b1;
        push_exp(4'b1101, t0 + 4 * 6001, 18, 20, 18, 20, 46, 48);

        // Frames 5-6: channel 0 idle, channel 1 green; each change needs a second frame.
        wait_until(t0 + 4 * 6001 + 2);
        set_ch(0, 0, 0, 0);
        set_ch(1, 50, 20, 50);
        push_exp(4'b1101, t0 + 5 * 6001, 18, 20, 46, 48, 18, 20);
        wait_until(t0 + 5 * 6001 + 2);
        rd_ch = 1'b0;
        push_exp(4'b1000, t0 + 6 * 6001, 0, 0, 0, 0, 0, 0);

        // Frame 7: edges only inside the settle window must not count.
        wait_until(t0 + 6 * 6001 + 2);
        set_ch(1, 0, 0, 0);
        settle_m = 1'b1;
        rd_ch = 1'b1;
        push_exp(4'b1000, t0 + 7 * 6001, 0, 0, 0, 0, 0, 0);

        // Frame 8: drop en mid green phase, then restart a full frame.
        wait_until(t0 + 7 * 6001 + 2);
        settle_m = 1'b0;
        rd_ch = 1'b0;
        wait_until(t0 + 7 * 6001 + 3000);
        td = ncyc;
        en = 1'b0;
        wait_until(td + 3);
        chk("dis_sel", int'(sel), 0);
        wait_until(td + 499);
        chk("dis_color_held", int'(color), 4'b1000);
        wait_until(td + 500);
        te = ncyc;
        en = 1'b1;
        push_exp(4'b0000, te + 6001, 0, 0, 0, 0, 0, 0);
        wait_until(te + 1);
        chk("reen_sel", int'(sel), 0);
        wait_until(te + 6001 + 3);

        budget = 0;
        while ((sb_q.size() != 0 || !sat_done) && budget < 10000) begin
            @(negedge clkus);
            budget++;
        end
        chk("pending_frames", sb_q.size(), 0);
        chk("sat_done", int'(sat_done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
